// File: rtl/dffe_mux_lfsr_pkg.sv
// Shared constants and helpers for the 8-bit Galois LFSR piece selector.
// Holds the LFSR step equation and the modulo-6 piece-index reduction.
package dffe_mux_lfsr_pkg;

   localparam int unsigned LFSR_W     = 8;
   localparam int unsigned Q_W        = 3;
   localparam int unsigned PIECE_MOD  = 6;
   localparam int unsigned LOAD_EDGES = 2;

   // Bits whose next value is XORed with the feedback bit r[0].
   localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0110_0100;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] r);
      logic f;
      f = r[0];
      return {f, r[LFSR_W-1:1] ^ (TAP_MASK[LFSR_W-2:0] & {(LFSR_W-1){f}})};
   endfunction

   function automatic logic [Q_W-1:0] piece_of(input logic [LFSR_W-1:0] r);
      logic [LFSR_W-1:0] rem;
      rem = r % 8'd6;
      return rem[Q_W-1:0];
   endfunction

endpackage

// File: rtl/dffe_mux_lfsr_cells.sv
// Leaf cells of the LFSR datapath: an enabled D flip-flop with async clear
// and a 2:1 multiplexer.
module dffe_ref (
   input  logic clk,
   input  logic d,
   input  logic en,
   input  logic clr,
   output logic q
);

   // Storage bit: async clear wins, otherwise capture d when enabled.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q <= 1'b0;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

module mux2In (
   input  logic in0,
   input  logic in1,
   input  logic sel,
   output logic out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/dffe_mux_lfsr.sv
// 8-bit Galois LFSR piece source: two-edge seed load after reset, then one
// step per clock; q is the state reduced modulo 6.
module dffe_mux_lfsr
   import dffe_mux_lfsr_pkg::*;
(
   input  logic              clock,
   input  logic              resetn,
   input  logic [LFSR_W-1:0] seed,
   output logic [Q_W-1:0]    q
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] lfsr_n_s;
   logic [LFSR_W-1:0] cell_d_s;
   logic              clr_s;
   logic              load_q;
   logic              load_d;
   logic              cnt_q;
   logic              cnt_d;

   assign clr_s    = ~resetn;
   assign lfsr_n_s = lfsr_step(state_q);

   for (genvar i = 0; i < LFSR_W; i++) begin : g_cell
      mux2In u_mux (
         .in0 (lfsr_n_s[i]),
         .in1 (seed[i]),
         .sel (load_q),
         .out (cell_d_s[i])
      );

      dffe_ref u_ff (
         .clk (clock),
         .d   (cell_d_s[i]),
         .en  (1'b1),
         .clr (clr_s),
         .q   (state_q[i])
      );
   end

   // Load phase spans two edges: the first arms cnt, the second drops load.
   always_comb begin
      cnt_d  = cnt_q;
      load_d = load_q;
      if (!cnt_q) begin
         cnt_d = 1'b1;
      end else begin
         load_d = 1'b0;
      end
   end

   // Load-control register; reset re-arms the seed load.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         load_q <= 1'b1;
         cnt_q  <= 1'b0;
      end else begin
         load_q <= load_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q = piece_of(state_q);

endmodule

// File: tb/tb_dffe_mux_lfsr.sv
// Directed self-checking bench for dffe_mux_lfsr: reset, load, seed timing,
// zero seed, mid-run reset and a long run against a reference model.
module tb_dffe_mux_lfsr;

   logic       clock;
   logic       resetn;
   logic [7:0] seed;
   logic [2:0] q;

   int n_checks;
   int n_fail;

   dffe_mux_lfsr dut (
      .clock  (clock),
      .resetn (resetn),
      .seed   (seed),
      .q      (q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] model_step(input logic [7:0] r);
      logic [7:0] n;
      n[0] = r[1];
      n[1] = r[2];
      n[2] = r[3] ^ r[0];
      n[3] = r[4];
      n[4] = r[5];
      n[5] = r[6] ^ r[0];
      n[6] = r[7] ^ r[0];
      n[7] = r[0];
      return n;
   endfunction

   // Hold reset, then release asynchronously between edges.
   task automatic apply_reset(input logic [7:0] s);
      @(negedge clock);
      resetn = 1'b0;
      seed   = s;
      repeat (2) @(negedge clock);
      #2;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clock);
      resetn = 1'b0;
      seed   = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_checks++;
         if (dut.state_q !== 8'h00 || q !== 3'd0) begin
            $display("FAIL reset_hold: r=%h q=%0d required r=00 q=0", dut.state_q, q);
            n_fail++;
         end
      end
      #2;
      resetn = 1'b1;
      #1;
      n_checks++;
      if (dut.state_q !== 8'h00 || q !== 3'd0) begin
         $display("FAIL reset_release_glitch: r=%h q=%0d required r=00 q=0", dut.state_q, q);
         n_fail++;
      end
   endtask

   task automatic test_load_step();
      logic [7:0] exp_r [5];
      logic [2:0] exp_q [5];
      exp_r = '{8'h01, 8'h01, 8'hE4, 8'h72, 8'h39};
      exp_q = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd3};
      apply_reset(8'h01);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_checks++;
         if (dut.state_q !== exp_r[i] || q !== exp_q[i]) begin
            $display("FAIL load_step edge%0d: r=%h q=%0d required r=%h q=%0d",
                     i + 1, dut.state_q, q, exp_r[i], exp_q[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_seed_change();
      logic [7:0] exp_r [5];
      exp_r = '{8'hFF, 8'h01, 8'hE4, 8'h72, 8'h39};
      apply_reset(8'hFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_checks++;
         if (dut.state_q !== exp_r[i]) begin
            $display("FAIL seed_change edge%0d: r=%h required r=%h", i + 1, dut.state_q, exp_r[i]);
            n_fail++;
         end
         if (i == 0) seed = 8'h01;
         else        seed = 8'h5A + 8'(i);
      end
   endtask

   task automatic test_zero_seed();
      apply_reset(8'h00);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         n_checks++;
         if (dut.state_q !== 8'h00 || q !== 3'd0) begin
            $display("FAIL zero_seed cycle%0d: r=%h q=%0d required r=00 q=0", i, dut.state_q, q);
            n_fail++;
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] exp_r [5];
      exp_r = '{8'h01, 8'h01, 8'hE4, 8'h72, 8'h39};
      apply_reset(8'h01);
      repeat (10) @(negedge clock);
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (dut.state_q !== 8'h00 || q !== 3'd0) begin
         $display("FAIL mid_reset_clear: r=%h q=%0d required r=00 q=0", dut.state_q, q);
         n_fail++;
      end
      repeat (2) @(negedge clock);
      #2;
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_checks++;
         if (dut.state_q !== exp_r[i]) begin
            $display("FAIL mid_reset_reload edge%0d: r=%h required r=%h", i + 1, dut.state_q, exp_r[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_period();
      logic [7:0] s;
      logic [7:0] m;
      int         model_period;
      int         dut_period;
      int         n_cycles;
      s = 8'h3C;
      m = model_step(s);
      model_period = 1;
      while (m != s && model_period < 256) begin
         m = model_step(m);
         model_period++;
      end
      n_cycles   = (model_period + 2 > 300) ? model_period + 2 : 300;
      dut_period = 0;
      apply_reset(s);
      repeat (2) @(negedge clock);
      m = s;
      for (int i = 1; i <= n_cycles; i++) begin
         @(negedge clock);
         m = model_step(m);
         n_checks++;
         if (dut.state_q !== m || q !== 3'(m % 8'd6) || q > 3'd5 || dut.state_q == 8'h00) begin
            $display("FAIL period_run cycle%0d: r=%h q=%0d required r=%h q=%0d",
                     i, dut.state_q, q, m, m % 8'd6);
            n_fail++;
         end
         if (dut_period == 0 && dut.state_q === s) dut_period = i;
      end
      n_checks++;
      if (dut_period != model_period) begin
         $display("FAIL period_length: measured=%0d required=%0d", dut_period, model_period);
         n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      seed     = 8'h00;
      test_reset();
      test_load_step();
      test_seed_change();
      test_zero_seed();
      test_mid_reset();
      test_period();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
